// File: rtl/cgra_cfg_pkg.sv
// rtl/cgra_cfg_pkg.sv - shared types and constants for the CGRA config sequencer
package cgra_cfg_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_SETTLE,
    ST_DONE
  } cfg_state_t;

  localparam int CFG_PAIR_ADDR_W = 32;
  localparam int CFG_PAIR_DATA_W = 32;

  // Address value that means "nothing on the bus"
  localparam logic [CFG_PAIR_ADDR_W-1:0] CFG_IDLE_ADDR = '0;

  // One configuration pair as delivered by the bitstream source
  typedef struct packed {
    logic [CFG_PAIR_ADDR_W-1:0] addr;
    logic [CFG_PAIR_DATA_W-1:0] data;
    logic                       last;
  } cfg_pair_t;

  // Number of bits needed to hold values 0..max_val (never less than 1)
  function automatic int cfg_cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/cfg_down_counter.sv
// rtl/cfg_down_counter.sv - loadable down-counter with zero flag, shared by HOLD and SETTLE
module cfg_down_counter #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load wins over decrement; the count parks at zero instead of wrapping
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/cgra_config_sequencer.sv
// rtl/cgra_config_sequencer.sv - drives (addr, data) config pairs onto the CGRA config bus
module cgra_config_sequencer
  import cgra_cfg_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int HOLD_CYCLES   = 1,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              start_in,
  input  logic              cfg_valid_in,
  output logic              cfg_ready_out,
  input  logic [ADDR_W-1:0] cfg_addr_in,
  input  logic [DATA_W-1:0] cfg_data_in,
  input  logic              cfg_last_in,
  output logic [ADDR_W-1:0] config_addr_out,
  output logic [DATA_W-1:0] config_data_out,
  output logic              busy_out,
  output logic              config_done_out,
  output logic [CNT_W-1:0]  word_count_out
);

  // One timer serves both intervals, so it is sized for the larger one
  localparam int TMR_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = cfg_cnt_width(TMR_MAX);
  localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] IDLE_ADDR  = ADDR_W'(CFG_IDLE_ADDR);

  cfg_state_t          r_state;
  logic                r_ready;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_last;
  logic                r_busy;
  logic                r_done;
  logic [CNT_W-1:0]    r_count;

  cfg_state_t          w_state;
  logic                w_ready;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic                w_last;
  logic                w_busy;
  logic                w_done;
  logic [CNT_W-1:0]    w_count;
  logic                w_tmr_load;
  logic [TMR_W-1:0]    w_tmr_val;
  logic                w_tmr_dec;
  logic                w_tmr_zero;

  cfg_down_counter #(
    .W(TMR_W)
  ) u_tmr (
    .i_clk      (clk_in),
    .i_reset    (reset_in),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  // Next-state and next-output decode; every output is registered below
  always_comb begin
    w_state    = r_state;
    w_ready    = r_ready;
    w_addr     = r_addr;
    w_data     = r_data;
    w_last     = r_last;
    w_busy     = r_busy;
    w_done     = r_done;
    w_count    = r_count;
    w_tmr_load = 1'b0;
    w_tmr_val  = HOLD_LOAD;
    w_tmr_dec  = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start_in) begin
          w_state = ST_FETCH;
          w_ready = 1'b1;
          w_busy  = 1'b1;
          w_done  = 1'b0;
          w_count = '0;
          w_addr  = IDLE_ADDR;
          w_data  = '0;
        end
      end

      ST_FETCH: begin
        w_ready = 1'b1;
        w_addr  = IDLE_ADDR;
        w_data  = '0;
        if (cfg_valid_in && r_ready) begin
          w_state    = ST_HOLD;
          w_ready    = 1'b0;
          w_addr     = cfg_addr_in;
          w_data     = cfg_data_in;
          w_last     = cfg_last_in;
          w_count    = (r_count == '1) ? r_count : r_count + 1'b1;
          w_tmr_load = 1'b1;
          w_tmr_val  = HOLD_LOAD;
        end
      end

      ST_HOLD: begin
        if (w_tmr_zero) begin
          w_addr = IDLE_ADDR;
          w_data = '0;
          if (r_last) begin
            if (SETTLE_CYCLES == 0) begin
              w_state = ST_DONE;
              w_busy  = 1'b0;
              w_done  = 1'b1;
            end else begin
              w_state    = ST_SETTLE;
              w_tmr_load = 1'b1;
              w_tmr_val  = SETTLE_LOAD;
            end
          end else begin
            // Always pass through FETCH, which guarantees one idle bus cycle between words
            w_state = ST_FETCH;
            w_ready = 1'b1;
          end
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (w_tmr_zero) begin
          w_state = ST_DONE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      default: begin
        w_state = ST_IDLE;
        w_ready = 1'b0;
        w_busy  = 1'b0;
        w_addr  = IDLE_ADDR;
        w_data  = '0;
      end
    endcase
  end

  // State and output registers; reset clears everything so no partial word survives
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_addr  <= IDLE_ADDR;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state;
      r_ready <= w_ready;
      r_addr  <= w_addr;
      r_data  <= w_data;
      r_last  <= w_last;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_count <= w_count;
    end
  end

  assign cfg_ready_out   = r_ready;
  assign config_addr_out = r_addr;
  assign config_data_out = r_data;
  assign busy_out        = r_busy;
  assign config_done_out = r_done;
  assign word_count_out  = r_count;

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// tb/tb_cgra_config_sequencer.sv - scoreboard bench for cgra_config_sequencer over three parameter sets
module tb_cgra_config_sequencer;
  import cgra_cfg_pkg::*;

  localparam int NU = 3;
  localparam int HOLD_T   [NU] = '{1, 2, 3};
  localparam int SETTLE_T [NU] = '{4, 3, 0};
  localparam int CNTW_T   [NU] = '{16, 16, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit fin_flag [NU];

  task automatic chk(input int u, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s: got %0h want %0h", u, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < NU; g++) begin : u
    localparam int H    = HOLD_T[g];
    localparam int S    = SETTLE_T[g];
    localparam int CW   = CNTW_T[g];
    localparam int CMAX = (1 << CW) - 1;

    logic          rst, start, valid, last;
    logic          ready, busy, done;
    logic [31:0]   addr, data, bus_a, bus_d;
    logic [CW-1:0] cnt;
    cfg_pair_t     exp_q [$];
    int            cnt_q [$];
    int            n_acc;

    cgra_config_sequencer #(
      .ADDR_W(32), .DATA_W(32), .HOLD_CYCLES(H), .SETTLE_CYCLES(S), .CNT_W(CW)
    ) dut (
      .clk_in          (clk),
      .reset_in        (rst),
      .start_in        (start),
      .cfg_valid_in    (valid),
      .cfg_ready_out   (ready),
      .cfg_addr_in     (addr),
      .cfg_data_in     (data),
      .cfg_last_in     (last),
      .config_addr_out (bus_a),
      .config_data_out (bus_d),
      .busy_out        (busy),
      .config_done_out (done),
      .word_count_out  (cnt)
    );

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    function automatic int sat(input int n);
      return (n > CMAX) ? CMAX : n;
    endfunction

    task automatic chk_zero(input string nm);
      chk(g, {nm, "_addr"}, bus_a, 32'h0);
      chk(g, {nm, "_data"}, bus_d, 32'h0);
      chk(g, {nm, "_busy"}, 32'(busy), 32'h0);
      chk(g, {nm, "_done"}, 32'(done), 32'h0);
      chk(g, {nm, "_cnt"}, 32'(cnt), 32'h0);
      chk(g, {nm, "_ready"}, 32'(ready), 32'h0);
    endtask

    // Offer one pair, optionally after an idle stretch with valid low in FETCH
    task automatic send(input cfg_pair_t p, input int stall);
      bit hs;
      hs = 1'b0;
      if (stall > 0) begin
        valid = 1'b0;
        for (int t = 0; t < 64 && !hs; t++) begin
          @(negedge clk);
          hs = ready;
          step();
        end
        chk(g, "ready_seen", 32'(hs), 32'h1);
        repeat (stall) begin
          @(negedge clk);
          chk(g, "stall_ready", 32'(ready), 32'h1);
          chk(g, "stall_addr", bus_a, 32'h0);
          chk(g, "stall_data", bus_d, 32'h0);
          step();
        end
      end
      addr  = p.addr;
      data  = p.data;
      last  = p.last;
      valid = 1'b1;
      n_acc++;
      exp_q.push_back(p);
      cnt_q.push_back(sat(n_acc));
      hs = 1'b0;
      for (int t = 0; t < 64 && !hs; t++) begin
        @(negedge clk);
        hs = ready;
        step();
      end
      chk(g, "hs_seen", 32'(hs), 32'h1);
      valid = 1'b0;
      addr  = $urandom;
      data  = $urandom;
      last  = 1'($urandom_range(0, 1));
    endtask

    // Stimulus: a fixed sequence of passes with randomized payloads and pacing
    initial begin : drv
      cfg_pair_t p;
      int nw, st;
      bit bstart, d;
      rst = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0;
      addr = '0; data = '0; n_acc = 0;
      step();
      step();
      @(negedge clk);
      chk_zero("reset");
      step();
      rst = 1'b0;
      valid = 1'b1;
      @(negedge clk);
      chk(g, "idle_ready", 32'(ready), 32'h0);
      chk(g, "idle_busy", 32'(busy), 32'h0);
      step();
      valid = 1'b0;

      for (int ps = 0; ps < 6; ps++) begin
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        chk(g, "start_busy", 32'(busy), 32'h1);
        chk(g, "start_ready", 32'(ready), 32'h1);
        chk(g, "start_done", 32'(done), 32'h0);
        chk(g, "start_cnt", 32'(cnt), 32'h0);
        step();
        n_acc = 0;

        nw = (ps == 0) ? 1 : (ps == 1) ? 5 : (ps <= 3) ? 3 : int'($urandom_range(1, 4));
        for (int w = 0; w < nw; w++) begin
          p.addr = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
          p.data = $urandom;
          p.last = (w == nw - 1);
          if (g == 0 && ps == 0) begin
            p.addr = 32'h0001_0003;
            p.data = 32'h0000_0002;
          end
          if (ps == 2 && w == 2) p.addr = 32'h0;
          st = (ps < 2) ? 0 : (ps == 2 && w == 1) ? 10 : (ps <= 3) ? 0 : int'($urandom_range(0, 3));
          send(p, st);
          if (ps == 3) break;
          bstart = (ps == 1 && w == 1) || (ps >= 4 && $urandom_range(0, 2) == 0);
          if (bstart) begin
            start = 1'b1;
            step();
            start = 1'b0;
          end
        end

        if (ps == 3) begin
          rst = 1'b1;
          step();
          @(negedge clk);
          chk_zero("midreset");
          step();
          rst = 1'b0;
          n_acc = 0;
        end else begin
          d = 1'b0;
          for (int t = 0; t < 64 && !d; t++) begin
            @(negedge clk);
            d = done;
            step();
          end
          chk(g, "done_seen", 32'(d), 32'h1);
          repeat (2) begin
            @(negedge clk);
            chk(g, "donelvl_done", 32'(done), 32'h1);
            chk(g, "donelvl_busy", 32'(busy), 32'h0);
            chk(g, "donelvl_cnt", 32'(cnt), 32'(sat(n_acc)));
            chk(g, "donelvl_addr", bus_a, 32'h0);
            step();
          end
        end
      end
      fin_flag[g] = 1'b1;
    end

    // Monitor: on every handshake, pop the expected pair and follow its bus timeline
    initial begin : mon
      cfg_pair_t e;
      int ec;
      bit ab, have;
      have = 1'b0;
      while (!fin_flag[g]) begin
        if (!have) @(negedge clk);
        have = 1'b0;
        if (!rst && valid && ready) begin
          if (exp_q.size() == 0) begin
            chk(g, "hs_expected", 32'(exp_q.size()), 32'h1);
          end else begin
            e  = exp_q.pop_front();
            ec = cnt_q.pop_front();
            ab = 1'b0;
            for (int i = 1; i <= H + 1 + (e.last ? S : 0) && !ab; i++) begin
              @(negedge clk);
              if (rst) begin
                ab = 1'b1;
                exp_q.delete();
                cnt_q.delete();
              end else if (i <= H) begin
                chk(g, "hold_addr", bus_a, e.addr);
                chk(g, "hold_data", bus_d, e.data);
                chk(g, "hold_ready", 32'(ready), 32'h0);
                chk(g, "hold_busy", 32'(busy), 32'h1);
                chk(g, "hold_cnt", 32'(cnt), 32'(ec));
              end else if (!e.last) begin
                chk(g, "gap_addr", bus_a, 32'h0);
                chk(g, "gap_data", bus_d, 32'h0);
                chk(g, "gap_ready", 32'(ready), 32'h1);
              end else if (i < H + 1 + S) begin
                chk(g, "settle_addr", bus_a, 32'h0);
                chk(g, "settle_done", 32'(done), 32'h0);
                chk(g, "settle_busy", 32'(busy), 32'h1);
                chk(g, "settle_ready", 32'(ready), 32'h0);
              end else begin
                chk(g, "done_rise", 32'(done), 32'h1);
                chk(g, "done_busy", 32'(busy), 32'h0);
                chk(g, "done_cnt", 32'(cnt), 32'(ec));
                chk(g, "done_addr", bus_a, 32'h0);
              end
            end
            if (!ab) have = 1'b1;
          end
        end
      end
    end
  end

  // Wait for every unit's stimulus to finish, bounded, then report
  initial begin : top_ctl
    bit all;
    all = 1'b0;
    for (int t = 0; t < 20000 && !all; t++) begin
      @(posedge clk);
      all = fin_flag[0] && fin_flag[1] && fin_flag[2];
    end
    chk(0, "all_finished", 32'(all), 32'h1);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
